pipe_stage_elastic: RTL and testbench

Parametrised successor to the single-register f-d-e-m-w stage slot. It carries an opaque DATA_W payload through a DEPTH-entry elastic buffer and uses the same valid/allowin handshake as the existing stages. It adds flush, occupancy reporting and multi-entry buffering, so a downstream stall no longer back-pressures upstream immediately. It drops in between any two pipeline stages; callers concatenate their stage fields into pre_data.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/pipe_stage_elastic_mem.sv | 23 ++
 rtl/pipe_stage_elastic.sv | 97 +++++++++
 tb/tb_pipe_stage_elastic.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared helpers and names for elastic pipeline stages
package pipe_pkg;

  localparam string HS_PRE_VALID   = "pre_valid";
  localparam string HS_CUR_ALLOWIN = "cur_allowin";
  localparam string HS_GOON_VALID  = "goon_valid";
  localparam string HS_POST_ALLOWIN = "post_allowin";

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

  // Width needed to count 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return clog2(depth + 1);
  endfunction

  // Pointer width, never below one bit so DEPTH=1 still has a legal vector.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_stage_elastic_mem.sv
// rtl/pipe_stage_elastic_mem.sv - DEPTH x DATA_W storage, one write and one async read port
module pipe_stage_elastic_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int PTR_W  = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  wr_ptr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  rd_ptr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic FIFO pipeline stage; PIPE_STAGE_PERF_EN adds stall_cycles
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int PERF_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     cur_stall,
  input  logic                     pre_valid,
  input  logic [DATA_W-1:0]        pre_data,
  output logic                     cur_allowin,
  input  logic                     post_allowin,
  output logic                     goon_valid,
  output logic [DATA_W-1:0]        data,
  output logic                     reg_valid,
  output logic [occ_w(DEPTH)-1:0]  occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [PERF_W-1:0]        stall_cycles
`endif
);

  localparam int CW = occ_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [CW-1:0]     count;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W-1:0] rdata;
  logic              push;
  logic              pop;

  assign goon_valid  = (count != '0) && !cur_stall && !flush;
  assign pop         = goon_valid && post_allowin;
  // A pop frees the slot in the same cycle, so a full stage still accepts.
  assign cur_allowin = !reset || (count != FULL) || pop;
  assign push        = pre_valid && cur_allowin;

  assign data      = (count == '0) ? '0 : rdata;
  assign reg_valid = (count != '0);
  assign occupancy = count;

  pipe_stage_elastic_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PW)
  ) u_mem (
    .clk    (clk),
    .we     (push && !flush && reset),
    .wr_ptr (wr_ptr),
    .wdata  (pre_data),
    .rd_ptr (rd_ptr),
    .rdata  (rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      stall_cycles <= '0;
    end else if ((count != '0) && !pop && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end
`endif

  // Occupancy bookkeeping must never wrap; parameters must be sane.
  always_ff @(posedge clk) begin
    if (reset && !flush) begin
      assert (!(push && !pop && (count == FULL)));
      assert (!(pop && (count == '0)));
      assert (PERF_W > 0 && DATA_W > 0);
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - bench for pipe_stage_elastic at DEPTH 1, 2 and 3
module tb_pipe_stage_elastic;

  logic        clk;
  logic        rst;
  logic        flush [3];
  logic        stall [3];
  logic        pv    [3];
  logic [31:0] pd    [3];
  logic        pa    [3];
  logic        allow [3];
  logic        goon  [3];
  logic [31:0] dout  [3];
  logic        rv    [3];
  logic [7:0]  occ   [3];
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] sc    [3];
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [pipe_pkg::occ_w(g + 1)-1:0] occ_l;
    assign occ[g] = 8'(occ_l);
    pipe_stage_elastic #(.DATA_W(32), .DEPTH(g + 1), .PERF_W(32)) u_dut (
      .clk          (clk),
      .reset        (rst),
      .flush        (flush[g]),
      .cur_stall    (stall[g]),
      .pre_valid    (pv[g]),
      .pre_data     (pd[g]),
      .cur_allowin  (allow[g]),
      .post_allowin (pa[g]),
      .goon_valid   (goon[g]),
      .data         (dout[g]),
      .reg_valid    (rv[g]),
      .occupancy    (occ_l)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cycles (sc[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] q   [3][$];
  logic [31:0] em  [3][$];
  int unsigned sc_m [3];
  bit          sr_v;
  bit          pushed [3];
  int          max_occ3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 3; k++) begin
      flush[k] = 1'b0; stall[k] = 1'b0; pv[k] = 1'b0; pd[k] = '0; pa[k] = 1'b0;
    end
  endtask

  // One clock: check every instance against the queue model, then advance it.
  task automatic cycle();
    bit pop_m [3];
    bit sr_allow;
    int sz;
    #1;
    sr_allow = !sr_v || (!stall[0] && pa[0]);
    for (int k = 0; k < 3; k++) begin
      sz = q[k].size();
      pop_m[k]  = (sz != 0) && !stall[k] && !flush[k] && pa[k];
      pushed[k] = pv[k] && ((sz != k + 1) || pop_m[k]);
      chk($sformatf("occ%0d", k),   32'(occ[k]), 32'(sz));
      chk($sformatf("rv%0d", k),    32'(rv[k]), 32'(sz != 0));
      chk($sformatf("goon%0d", k),  32'(goon[k]), 32'((sz != 0) && !stall[k] && !flush[k]));
      chk($sformatf("allow%0d", k), 32'(allow[k]), 32'((sz != k + 1) || pop_m[k]));
      chk($sformatf("data%0d", k),  dout[k], (sz != 0) ? q[k][0] : 32'h0);
`ifdef PIPE_STAGE_PERF_EN
      chk($sformatf("stall_cycles%0d", k), sc[k], sc_m[k]);
`endif
      if (goon[k] === 1'b1 && pa[k]) em[k].push_back(dout[k]);
    end
    chk("sr_allow", 32'(allow[0]), 32'(sr_allow));
    chk("sr_goon",  32'(goon[0]),  32'(sr_v && !stall[0]));
    if (32'(occ[2]) > max_occ3) max_occ3 = 32'(occ[2]);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (flush[k]) begin
        q[k].delete();
        sc_m[k] = 0;
      end else begin
        if ((q[k].size() != 0) && !pop_m[k] && sc_m[k] != 32'hFFFF_FFFF) sc_m[k]++;
        if (pop_m[k]) void'(q[k].pop_front());
        if (pushed[k]) q[k].push_back(pd[k]);
      end
    end
    if (flush[0]) sr_v = 1'b0;
    else if (sr_allow) sr_v = pv[0];
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      q[k].delete();
      sc_m[k] = 0;
      chk($sformatf("rst_occ%0d", k),   32'(occ[k]), 32'h0);
      chk($sformatf("rst_rv%0d", k),    32'(rv[k]), 32'h0);
      chk($sformatf("rst_goon%0d", k),  32'(goon[k]), 32'h0);
      chk($sformatf("rst_data%0d", k),  dout[k], 32'h0);
      chk($sformatf("rst_allow%0d", k), 32'(allow[k]), 32'h1);
`ifdef PIPE_STAGE_PERF_EN
      chk($sformatf("rst_sc%0d", k), sc[k], 32'h0);
`endif
    end
    sr_v = 1'b0;
    rst  = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_order [4];
    int next_v;
    int budget;
    bit saw_dead;

    idle_inputs();
    rst = 1'b0;
    max_occ3 = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single pass-through at DEPTH=2.
    pv[1] = 1'b1; pd[1] = 32'hA5A5_0001; pa[1] = 1'b1;
    cycle();
    pv[1] = 1'b0;
    cycle();
    cycle();

    // Fill, then release back-pressure with a simultaneous push and pop.
    pa[1] = 1'b0; pv[1] = 1'b1; pd[1] = 32'h1;
    cycle();
    pd[1] = 32'h2;
    cycle();
    pd[1] = 32'h3;
    cycle();
    pa[1] = 1'b1;
    cycle();
    pv[1] = 1'b0;
    repeat (3) cycle();
    exp_order = '{32'hA5A5_0001, 32'h1, 32'h2, 32'h3};
    chk("order_len", 32'(em[1].size()), 32'd4);
    for (int i = 0; i < 4 && i < em[1].size(); i++)
      chk($sformatf("order%0d", i), em[1][i], exp_order[i]);

    // Flush a full buffer while a push is offered.
    pa[1] = 1'b0; pv[1] = 1'b1; pd[1] = 32'h11;
    cycle();
    pd[1] = 32'h12;
    cycle();
    flush[1] = 1'b1; pd[1] = 32'hDEAD;
    cycle();
    flush[1] = 1'b0; pv[1] = 1'b0; pa[1] = 1'b1;
    repeat (2) cycle();

    // Stall holds a single entry despite downstream readiness.
    pa[1] = 1'b0; pv[1] = 1'b1; pd[1] = 32'h55;
    cycle();
    pv[1] = 1'b0; stall[1] = 1'b1; pa[1] = 1'b1;
    repeat (3) cycle();
    stall[1] = 1'b0;
    repeat (2) cycle();
    saw_dead = 1'b0;
    for (int k = 0; k < 3; k++)
      foreach (em[k][i]) if (em[k][i] == 32'hDEAD) saw_dead = 1'b1;
    chk("dead_dropped", 32'(saw_dead), 32'h0);
    chk("after_stall_last", em[1][em[1].size()-1], 32'h55);

    // DEPTH=3 wrap: 0..9 with random downstream readiness.
    idle_inputs();
    next_v = 0;
    budget = 0;
    while (em[2].size() < 10 && budget < 300) begin
      pv[2] = (next_v < 10);
      pd[2] = 32'(next_v);
      pa[2] = 1'($urandom_range(0, 1));
      cycle();
      if (pushed[2]) next_v++;
      budget++;
    end
    chk("wrap_count", 32'(em[2].size()), 32'd10);
    for (int i = 0; i < 10 && i < em[2].size(); i++)
      chk($sformatf("wrap%0d", i), em[2][i], 32'(i));
    chk("max_occ3_le3", 32'(max_occ3 <= 3), 32'h1);

    // DEPTH=1 random trace against a classic single-register stage, reset mid-burst.
    idle_inputs();
    for (int c = 0; c < 50; c++) begin
      pv[0]    = 1'($urandom_range(0, 1));
      pd[0]    = $urandom;
      stall[0] = 1'($urandom_range(0, 3) == 0);
      pa[0]    = 1'($urandom_range(0, 2) != 0);
      if (c == 25) do_reset();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
